// File: rtl/dac_spi_tx.sv
// Serial transmitter for a 12-bit SPI DAC: 16-bit frame {2'b00, mode, data}, MSB first,
// with SYNC framing, an idle-high serial clock and a minimum SYNC-high gap between frames.
module dac_spi_tx #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 4
) (
    input  logic        Clock_Nexys,
    input  logic        Reset,
    input  logic        start,
    input  logic [11:0] Dato,
    input  logic [1:0]  modo,
    output logic        SYNC,
    output logic        Clock_DAC,
    output logic        DIN,
    output logic        busy,
    output logic        done
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]    state_reg;
    logic [15:0]   shreg_reg;
    logic [DW-1:0] div_cnt_reg;
    logic [3:0]    bit_cnt_reg;
    logic [GW-1:0] gap_cnt_reg;
    logic          sync_reg;
    logic          sclk_reg;
    logic          din_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [15:0]   frame_word;

    assign frame_word = {2'b00, modo, Dato};

    always_ff @(posedge Clock_Nexys) begin
        if (Reset) begin
            state_reg   <= ST_IDLE;
            shreg_reg   <= '0;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            sync_reg    <= 1'b1;
            sclk_reg    <= 1'b1;
            din_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        shreg_reg   <= frame_word;
                        din_reg     <= frame_word[15];
                        sync_reg    <= 1'b0;
                        sclk_reg    <= 1'b1;
                        busy_reg    <= 1'b1;
                        div_cnt_reg <= '0;
                        bit_cnt_reg <= '0;
                        state_reg   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt_reg == DIV_LAST) begin
                        div_cnt_reg <= '0;
                        sclk_reg    <= ~sclk_reg;
                        // Clock is low here, so this wrap is a rising edge: advance DIN.
                        if (!sclk_reg) begin
                            if (bit_cnt_reg == 4'd15) begin
                                sync_reg    <= 1'b1;
                                sclk_reg    <= 1'b1;
                                din_reg     <= 1'b0;
                                done_reg    <= 1'b1;
                                gap_cnt_reg <= '0;
                                state_reg   <= ST_GAP;
                            end else begin
                                shreg_reg   <= {shreg_reg[14:0], 1'b0};
                                din_reg     <= shreg_reg[14];
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DW'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GW'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    sync_reg  <= 1'b1;
                    sclk_reg  <= 1'b1;
                    din_reg   <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign SYNC      = sync_reg;
    assign Clock_DAC = sclk_reg;
    assign DIN       = din_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Randomized and directed bench for dac_spi_tx: a frame-level model predicts accepted
// frames, and a monitor decodes DIN on falling Clock_DAC edges and scores each done pulse.
module tb_dac_spi_tx;

    localparam int D   = 4;
    localparam int GAP = 4;

    logic        Clock_Nexys;
    logic        Reset;
    logic        start;
    logic [11:0] Dato;
    logic [1:0]  modo;
    logic        SYNC;
    logic        Clock_DAC;
    logic        DIN;
    logic        busy;
    logic        done;

    dac_spi_tx #(.CLK_DIV(D), .GAP_CYC(GAP)) dut (
        .Clock_Nexys(Clock_Nexys),
        .Reset(Reset),
        .start(start),
        .Dato(Dato),
        .modo(modo),
        .SYNC(SYNC),
        .Clock_DAC(Clock_DAC),
        .DIN(DIN),
        .busy(busy),
        .done(done)
    );

    initial Clock_Nexys = 1'b0;
    always #5 Clock_Nexys = ~Clock_Nexys;

    typedef struct {
        logic [15:0] word;
        int          done_edge;
    } exp_t;

    exp_t exp_q[$];
    int   edge_cnt   = 0;
    int   model_free = 0;
    int   accepts    = 0;
    int   done_cnt   = 0;
    int   tests      = 0;
    int   fails      = 0;
    int   fall_edges[$];
    logic prev_sync_s = 1'b1;

    always @(posedge Clock_Nexys) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // One clock cycle of stimulus; the model decides from frame timing alone whether start is taken.
    task automatic cyc(input logic st, input logic [11:0] d, input logic [1:0] m, input logic rst);
        int n;
        n     = edge_cnt + 1;
        start = st;
        Dato  = d;
        modo  = m;
        Reset = rst;
        if (rst) begin
            exp_q.delete();
            model_free = n + 1;
        end else if (st && n >= model_free) begin
            exp_q.push_back('{word: {2'b00, m, d}, done_edge: n + 32 * D});
            model_free = n + 32 * D + GAP + 1;
            accepts++;
        end
        @(posedge Clock_Nexys);
        #1;
        if (prev_sync_s === 1'b1 && SYNC === 1'b0) fall_edges.push_back(edge_cnt);
        prev_sync_s = SYNC;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 12'($urandom), 2'($urandom), 1'b0);
    endtask

    // Monitor: decode the serial word and score it when done fires.
    logic [15:0] mon_bits = '0;
    int          mon_n    = 0;
    int          low_cnt  = 0;
    logic        prev_sync = 1'b1, prev_sclk = 1'b1, prev_din = 1'b0;

    always @(negedge Clock_Nexys) begin
        exp_t e;
        if (prev_sync === 1'b1 && SYNC === 1'b0) begin
            mon_bits = '0;
            mon_n    = 0;
            low_cnt  = 0;
        end
        if (SYNC === 1'b0) low_cnt++;
        if (SYNC === 1'b0 && prev_sclk === 1'b1 && Clock_DAC === 1'b0) begin
            chk("din_setup_stable", {31'd0, DIN}, {31'd0, prev_din});
            mon_bits = {mon_bits[14:0], DIN};
            mon_n++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("[TB] frame word=0x%04h expected=0x%04h done_edge=%0d expected_edge=%0d",
                         mon_bits, e.word, edge_cnt, e.done_edge);
                chk("frame_word", {16'd0, mon_bits}, {16'd0, e.word});
                chk("falling_edges", mon_n, 16);
                chk("done_time", edge_cnt, e.done_edge);
                chk("sync_low_len", low_cnt, 32 * D);
                chk("end_lines", {28'd0, SYNC, Clock_DAC, DIN, busy}, 32'b1101);
            end
        end
        prev_sync = SYNC;
        prev_sclk = Clock_DAC;
        prev_din  = DIN;
    end

    initial begin
        int n, base_done, base_acc;
        start = 1'b0;
        Dato  = '0;
        modo  = '0;
        Reset = 1'b1;

        // Reset values
        cyc(1'b1, 12'hABC, 2'b01, 1'b1);
        cyc(1'b0, 12'h000, 2'b00, 1'b1);
        chk("rst_lines", {27'd0, SYNC, Clock_DAC, DIN, busy, done}, 32'b11000);
        cyc(1'b0, 12'h000, 2'b00, 1'b0);
        chk("post_rst_lines", {27'd0, SYNC, Clock_DAC, DIN, busy, done}, 32'b11000);

        // Basic frame and busy release timing
        n = edge_cnt + 1;
        cyc(1'b1, 12'hA5A, 2'b00, 1'b0);
        chk("t0_lines", {28'd0, SYNC, Clock_DAC, DIN, busy}, 32'b0101);
        while (edge_cnt < n + 32 * D + GAP - 1) cyc(1'b0, 12'h000, 2'b00, 1'b0);
        chk("busy_before_release", {31'd0, busy}, 32'd1);
        cyc(1'b0, 12'h000, 2'b00, 1'b0);
        chk("busy_release", {31'd0, busy}, 32'd0);
        idle(3);

        // Latched data is immune to mid-frame changes
        cyc(1'b1, 12'hFFF, 2'b11, 1'b0);
        for (int i = 0; i < 60; i++) cyc(1'b0, 12'hFFF, 2'b11, 1'b0);
        for (int i = 0; i < 80; i++) cyc(1'b0, 12'h000, 2'b00, 1'b0);

        // start held high: back-to-back frames
        base_done = done_cnt;
        base_acc  = accepts;
        fall_edges.delete();
        while (accepts - base_acc < 2)
            cyc(1'b1, (accepts == base_acc) ? 12'h555 : 12'h2AA, 2'b00, 1'b0);
        idle(32 * D + GAP + 4);
        chk("held_done_pulses", done_cnt - base_done, 2);
        chk("held_frames_seen", fall_edges.size(), 2);
        if (fall_edges.size() == 2) begin
            chk("held_period", fall_edges[1] - fall_edges[0], 32 * D + GAP + 1);
            chk("held_gap_min", {31'd0, (fall_edges[1] - fall_edges[0] - 32 * D) >= GAP}, 32'd1);
        end

        // Reset at the 8th falling edge, with start asserted in the reset cycle
        n = edge_cnt + 1;
        base_done = done_cnt;
        cyc(1'b1, 12'h3C3, 2'b01, 1'b0);
        while (edge_cnt < n + 15 * D) cyc(1'b0, 12'h000, 2'b00, 1'b0);
        chk("fall8_sclk_low", {31'd0, Clock_DAC}, 32'd0);
        cyc(1'b1, 12'h111, 2'b00, 1'b1);
        chk("abort_lines", {27'd0, SYNC, Clock_DAC, DIN, busy, done}, 32'b11000);
        idle(2 * 32 * D);
        chk("abort_no_done", done_cnt - base_done, 0);
        cyc(1'b1, 12'h9C6, 2'b10, 1'b0);
        idle(32 * D + GAP + 2);
        chk("after_abort_done", done_cnt - base_done, 1);

        // start pulses during the frame and on the done cycle are dropped
        n = edge_cnt + 1;
        base_done = done_cnt;
        cyc(1'b1, 12'h7E1, 2'b00, 1'b0);
        while (edge_cnt < n + 50) cyc(1'b0, 12'h000, 2'b00, 1'b0);
        cyc(1'b1, 12'h0F0, 2'b00, 1'b0);
        while (edge_cnt < n + 32 * D) cyc(1'b0, 12'h000, 2'b00, 1'b0);
        chk("done_cycle_seen", {31'd0, done}, 32'd1);
        cyc(1'b1, 12'h0F0, 2'b01, 1'b0);
        idle(2 * 32 * D);
        chk("ignored_starts", done_cnt - base_done, 1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 19) == 0, 12'($urandom), 2'($urandom), 1'b0);
        idle(32 * D + GAP + 4);

        chk("queue_drained", exp_q.size(), 0);
        chk("total_done", done_cnt, accepts - 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
